selftrigger_record_capture: RTL and testbench
=============================================

# selftrigger_record_capture

Consumer of the self-trigger filter output. Captures the filtered sample stream `din` and its `trigger_in` pulse into a circular pretrigger buffer. On a trigger edge it freezes a fixed-length record: PRE_SAMPLES samples before the trigger, then the trigger sample and the samples after it. It then streams the record, preceded by a 4-word header, over a valid/ready interface to the readout path.

## Interface
Parameters:
- PRE_SAMPLES, 64: samples stored ahead of the trigger sample; range 1..REC_SAMPLES-1.
- REC_SAMPLES, 256: total samples per record, including pretrigger.
- ADDR_W, 9: buffer address width; 2^ADDR_W must be ≥ REC_SAMPLES + 1.

Ports:
- clk  in  1  single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  sample strobe; `din` and `trigger_in` are sampled only when high.
- din  in  16  signed filtered sample (filter `y` output).
- trigger_in  in  1  filter trigger level.
- channel_id  in  5  static channel number, captured at trigger.
- timestamp  in  48  free-running timestamp, captured at trigger.
- dout  out  16  record word.
- dout_valid  out  1  word valid.
- dout_ready  in  1  downstream accept.
- dout_last  out  1  final word of record.
- busy  out  1  high in CAPTURE and READOUT.
- missed_count  out  16  saturating count of dropped triggers.

## Operation
- Trigger edge: `trig_edge = enable & trigger_in & ~trig_prev`.
  - `trig_prev` updates on every enable cycle.
  - `trig_prev` clears on reset.
- FILL (entered after reset and after READOUT):
  - Each enable cycle writes `din` at `wr_ptr` and increments `wr_ptr` modulo 2^ADDR_W.
  - `fill_cnt` counts writes. When PRE_SAMPLES writes are complete, go to ARMED.
  - A `trig_edge` in FILL is dropped and increments `missed_count`.
- ARMED: writes continue as in FILL.
  - On `trig_edge`, the triggering sample is written at `wr_ptr`.
  - In the same cycle, latch `start_addr = wr_ptr - PRE_SAMPLES` (mod 2^ADDR_W), `channel_id` and `timestamp`.
  - Set `post_cnt = REC_SAMPLES - PRE_SAMPLES - 1` and go to CAPTURE.
  - If `post_cnt` is 0, go directly to READOUT instead.
- CAPTURE:
  - Each enable cycle writes a sample and decrements `post_cnt`.
  - The write performed when `post_cnt` is 1 is the final sample; go to READOUT.
  - A `trig_edge` in CAPTURE increments `missed_count`.
- READOUT:
  - No buffer writes occur. `enable`/`din` are ignored, except that `trig_edge` increments `missed_count`.
  - Emits REC_SAMPLES + 4 words:
    - h0 = {4'hA, 7'b0, channel_id}
    - h1 = timestamp[47:32]
    - h2 = timestamp[31:16]
    - h3 = timestamp[15:0]
    - then buffer words from `start_addr` upward, with address wrap.
  - `dout_last` is high only with the final sample word.
  - After the final word is accepted, `fill_cnt` clears and the block returns to FILL.
  - The pretrigger buffer is re-filled from scratch, so no stale samples are reused.
- Handshake (AXI-stream rules):
  - A word transfers when `dout_valid & dout_ready`.
  - While `dout_valid & ~dout_ready`, `dout`/`dout_last` hold stable and `dout_valid` stays high.
  - `dout_valid` never drops before acceptance.
- `missed_count` saturates at 16'hFFFF and is cleared only by reset.

## Timing
- Reset values:
  - `dout` 0, `dout_valid` 0, `dout_last` 0, `busy` 0, `missed_count` 0.
  - State FILL; `wr_ptr`, `fill_cnt`, `trig_prev` all 0.
- Reset assertion mid-record aborts capture or readout immediately. `dout_valid` drops asynchronously.
- Buffer RAM has 1-cycle synchronous read. Readout prefetches so that, with `dout_ready` held high, one word transfers per clock with no bubbles.
- Readout start: h0 asserts `dout_valid` exactly 2 clocks after the clock edge that wrote the final record sample.
- `busy` rises on the clock after `trig_edge` and falls on the clock after the `dout_last` transfer.
- Sample alignment: record sample index PRE_SAMPLES is the sample presented together with the trigger edge.
- When `enable` is low in FILL/ARMED/CAPTURE, the state is frozen.

## Test plan
- Ramp `din` = 0,1,2,… with `enable` always high. Trigger edge at sample 100 (PRE=64, REC=256) -> h0 = 16'hA000|channel_id, then the sample words are 36..291; `dout_last` on 291; total 260 words.
- `dout_ready` toggling 1/0 every cycle during readout -> identical word sequence; no word duplicated or lost; `dout` stable while stalled.
- Trigger at sample 30 (still in FILL), then another at 200 -> first trigger dropped, `missed_count` = 1, record starts at sample 136.
- Three trigger edges during CAPTURE plus two during READOUT -> `missed_count` = 5; a later trigger after FILL+ARMED yields a correct record.
- Trigger with `wr_ptr` near 2^ADDR_W - 10 (run 500 samples first) -> record contiguous across address wrap.
- `reset_n` pulsed low during READOUT word 50 -> outputs go to reset values at once; after release the next trigger yields a full correct record.

Source files
------------

// File: rtl/selftrigger_record_capture.sv
// Self-trigger record capture: keeps a circular pretrigger buffer of the
// filtered sample stream. On an accepted trigger edge it freezes a record of
// REC_SAMPLES samples (PRE_SAMPLES of them ahead of the trigger). It then
// streams a 4-word header plus the record over a valid/ready interface.
module selftrigger_record_capture #(
  parameter int PRE_SAMPLES = 64,
  parameter int REC_SAMPLES = 256,
  parameter int ADDR_W      = 9
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic signed [15:0] din,
  input  logic               trigger_in,
  input  logic [4:0]         channel_id,
  input  logic [47:0]        timestamp,
  output logic [15:0]        dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               dout_last,
  output logic               busy,
  output logic [15:0]        missed_count
);

  localparam int CNT_W = $clog2(REC_SAMPLES + 5);
  localparam logic [ADDR_W-1:0] PRE_A     = ADDR_W'(PRE_SAMPLES);
  localparam logic [ADDR_W-1:0] POST_INIT = ADDR_W'(REC_SAMPLES - PRE_SAMPLES - 1);
  localparam logic [CNT_W-1:0]  HDR_WORDS = CNT_W'(4);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(REC_SAMPLES + 3);

  typedef enum logic [1:0] {
    S_FILL,
    S_ARMED,
    S_CAPTURE,
    S_READOUT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [15:0]       mem [0:(1 << ADDR_W) - 1];
  logic [15:0]       rd_data;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] fill_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_addr;
  logic [4:0]        chan_q;
  logic [47:0]       ts_q;
  logic              trig_prev;
  logic [CNT_W-1:0]  out_idx;
  logic              ro_wait;

  logic              trig_edge;
  logic              do_write;
  logic              trig_accept;
  logic              miss_evt;
  logic              xfer;
  logic              last_xfer;
  logic              load;
  logic              load_sample;
  logic [15:0]       load_word;

  assign trig_edge   = enable & trigger_in & ~trig_prev;
  assign xfer        = dout_valid & dout_ready;
  assign last_xfer   = (state_q == S_READOUT) & xfer & dout_last;
  assign load        = (state_q == S_READOUT) & ~ro_wait & (out_idx <= LAST_IDX)
                       & (~dout_valid | dout_ready);
  assign load_sample = load & (out_idx >= HDR_WORDS);
  assign rd_addr     = load_sample ? rd_ptr + ADDR_W'(1) : rd_ptr;
  assign busy        = (state_q == S_CAPTURE) | (state_q == S_READOUT);

  // State register; reset aborts any capture or readout in progress
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus the write/accept/miss strobes for the datapath
  always_comb begin
    state_d     = state_q;
    do_write    = 1'b0;
    trig_accept = 1'b0;
    miss_evt    = 1'b0;
    case (state_q)
      S_FILL: begin
        if (enable) begin
          do_write = 1'b1;
          if (fill_cnt == PRE_A - ADDR_W'(1)) begin
            state_d = S_ARMED;
          end
        end
        if (trig_edge) begin
          miss_evt = 1'b1;
        end
      end
      S_ARMED: begin
        if (enable) begin
          do_write = 1'b1;
          if (trig_edge) begin
            trig_accept = 1'b1;
            state_d     = (POST_INIT == '0) ? S_READOUT : S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        if (enable) begin
          do_write = 1'b1;
          if (post_cnt == ADDR_W'(1)) begin
            state_d = S_READOUT;
          end
        end
        if (trig_edge) begin
          miss_evt = 1'b1;
        end
      end
      S_READOUT: begin
        if (trig_edge) begin
          miss_evt = 1'b1;
        end
        if (last_xfer) begin
          state_d = S_FILL;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  // Trigger history, write pointer, pretrigger fill count and post-trigger countdown
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_prev <= 1'b0;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      post_cnt  <= '0;
    end else begin
      if (enable) begin
        trig_prev <= trigger_in;
      end
      if (do_write) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (last_xfer) begin
        fill_cnt <= '0;
      end else if (do_write && state_q == S_FILL) begin
        fill_cnt <= fill_cnt + ADDR_W'(1);
      end
      if (trig_accept) begin
        post_cnt <= POST_INIT;
      end else if (do_write && state_q == S_CAPTURE) begin
        post_cnt <= post_cnt - ADDR_W'(1);
      end
    end
  end

  // Record metadata latched with the trigger; rd_ptr starts at the record's first sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chan_q <= '0;
      ts_q   <= '0;
      rd_ptr <= '0;
    end else begin
      if (trig_accept) begin
        chan_q <= channel_id;
        ts_q   <= timestamp;
        rd_ptr <= wr_ptr - PRE_A;
      end else if (load_sample) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
    end
  end

  // Saturating count of trigger edges that could not start a record
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      missed_count <= '0;
    end else if (miss_evt && missed_count != 16'hFFFF) begin
      missed_count <= missed_count + 16'd1;
    end
  end

  // Readout sequencing: one idle cycle after entry, then count words handed to the output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ro_wait <= 1'b0;
      out_idx <= '0;
    end else begin
      ro_wait <= (state_q != S_READOUT);
      if (state_q != S_READOUT) begin
        out_idx <= '0;
      end else if (load) begin
        out_idx <= out_idx + CNT_W'(1);
      end
    end
  end

  // Select the header field or the prefetched buffer word for the next output slot
  always_comb begin
    load_word = rd_data;
    if (out_idx == CNT_W'(0)) begin
      load_word = {4'hA, 7'b0, chan_q};
    end else if (out_idx == CNT_W'(1)) begin
      load_word = ts_q[47:32];
    end else if (out_idx == CNT_W'(2)) begin
      load_word = ts_q[31:16];
    end else if (out_idx == CNT_W'(3)) begin
      load_word = ts_q[15:0];
    end
  end

  // Output register: load a new word when empty or when the current one is taken
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else if (load) begin
      dout       <= load_word;
      dout_valid <= 1'b1;
      dout_last  <= (out_idx == LAST_IDX);
    end else if (xfer) begin
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end
  end

  // Sample buffer with one-cycle synchronous read; the read address runs one word ahead
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= din;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_selftrigger_record_capture.sv
// Testbench for selftrigger_record_capture: randomized and directed sample
// streams checked against a queue-based record model.
module tb_selftrigger_record_capture;

  localparam int PRE = 64;
  localparam int REC = 256;
  localparam int AW  = 9;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               enable = 1'b0;
  logic signed [15:0] din = '0;
  logic               trigger_in = 1'b0;
  logic [4:0]         channel_id = '0;
  logic [47:0]        timestamp = '0;
  logic [15:0]        dout;
  logic               dout_valid;
  logic               dout_ready = 1'b1;
  logic               dout_last;
  logic               busy;
  logic [15:0]        missed_count;

  int checks = 0;
  int failures = 0;

  logic [15:0] hist[$];
  logic [15:0] cur_rec[$];
  logic [15:0] exp_q[$];
  bit          exp_last_q[$];
  logic [15:0] got_q[$];
  int          m_post = 0;
  bit          m_reading = 1'b0;
  bit          m_prev = 1'b0;
  int          m_missed = 0;
  int          words_seen = 0;
  int          ramp_val = 0;
  int          ready_mode = 0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_dout = '0;
  logic        prev_last = 1'b0;
  logic [15:0] mon_word;
  bit          mon_last;

  selftrigger_record_capture #(
    .PRE_SAMPLES(PRE),
    .REC_SAMPLES(REC),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .din(din),
    .trigger_in(trigger_in),
    .channel_id(channel_id),
    .timestamp(timestamp),
    .dout(dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_last(dout_last),
    .busy(busy),
    .missed_count(missed_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: dout_ready = 1'b1;
      1: dout_ready = ~dout_ready;
      default: dout_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (dout_valid !== 1'b1 || dout !== prev_dout || dout_last !== prev_last) begin
          failures++;
          $display("[TB] FAIL stall_hold: valid=%b dout=%h last=%b required valid=1 dout=%h last=%b",
                   dout_valid, dout, dout_last, prev_dout, prev_last);
        end
      end
      if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_word: got %h required no transfer", dout);
        end else begin
          mon_word = exp_q.pop_front();
          mon_last = exp_last_q.pop_front();
          if (dout !== mon_word || dout_last !== mon_last) begin
            failures++;
            $display("[TB] FAIL record_word[%0d]: got %h last=%b required %h last=%b",
                     words_seen, dout, dout_last, mon_word, mon_last);
          end
          if (mon_last) begin
            m_reading = 1'b0;
            hist.delete();
          end
        end
        got_q.push_back(dout);
        words_seen++;
      end
      prev_stall = dout_valid && !dout_ready;
      prev_dout  = dout;
      prev_last  = dout_last;
    end
  end

  task automatic model_reset();
    hist.delete();
    cur_rec.delete();
    exp_q.delete();
    exp_last_q.delete();
    m_post    = 0;
    m_reading = 1'b0;
    m_prev    = 1'b0;
    m_missed  = 0;
  endtask

  task automatic model_miss();
    if (m_missed < 65535) m_missed++;
  endtask

  task automatic finish_capture();
    foreach (cur_rec[i]) begin
      exp_q.push_back(cur_rec[i]);
      exp_last_q.push_back(i == cur_rec.size() - 1);
    end
    m_reading = 1'b1;
  endtask

  task automatic model_step(input bit en, input logic [15:0] d, input bit trig);
    bit is_edge;
    is_edge = en && trig && !m_prev;
    if (en) m_prev = trig;
    if (m_reading) begin
      if (is_edge) model_miss();
    end else if (m_post > 0) begin
      if (en) begin
        cur_rec.push_back(d);
        m_post--;
        if (is_edge) model_miss();
        if (m_post == 0) finish_capture();
      end
    end else if (en) begin
      if (is_edge && hist.size() >= PRE) begin
        cur_rec.delete();
        cur_rec.push_back({4'hA, 7'b0, channel_id});
        cur_rec.push_back(timestamp[47:32]);
        cur_rec.push_back(timestamp[31:16]);
        cur_rec.push_back(timestamp[15:0]);
        foreach (hist[i]) cur_rec.push_back(hist[i]);
        cur_rec.push_back(d);
        m_post = REC - PRE - 1;
        if (m_post == 0) finish_capture();
      end else begin
        if (is_edge) model_miss();
        hist.push_back(d);
        if (hist.size() > PRE) void'(hist.pop_front());
      end
    end
  endtask

  task automatic push_sample(input bit en, input logic [15:0] d, input bit trig);
    @(posedge clk);
    #1;
    enable     = en;
    din        = d;
    trigger_in = trig;
    timestamp  = timestamp + 48'd1;
    model_step(en, d, trig);
  endtask

  task automatic ramp_push(input bit trig);
    push_sample(1'b1, 16'(ramp_val), trig);
    ramp_val++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n    = 1'b0;
    enable     = 1'b0;
    trigger_in = 1'b0;
    din        = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_n    = 1'b1;
    ramp_val   = 0;
    words_seen = 0;
    got_q.delete();
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((m_reading || m_post > 0) && n < limit) begin
      ramp_push(1'b0);
      n++;
    end
    checks++;
    if (m_reading || m_post > 0) begin
      failures++;
      $display("[TB] FAIL drain_timeout: record not finished after %0d cycles, %0d words pending required 0",
               n, exp_q.size());
    end
  endtask

  task automatic check_missed(input string name);
    checks++;
    if (missed_count !== 16'(m_missed)) begin
      failures++;
      $display("[TB] FAIL %s_missed: got %0d required %0d", name, missed_count, m_missed);
    end
  endtask

  task automatic check_record(input string name, input logic [15:0] first, input logic [15:0] last);
    checks++;
    if (got_q.size() != REC + 4) begin
      failures++;
      $display("[TB] FAIL %s_len: got %0d words required %0d", name, got_q.size(), REC + 4);
    end else if (got_q[4] !== first || got_q[REC + 3] !== last) begin
      failures++;
      $display("[TB] FAIL %s_bounds: got first=%0d last=%0d required first=%0d last=%0d",
               name, got_q[4], got_q[REC + 3], first, last);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dout !== 16'h0 || dout_valid !== 1'b0 || dout_last !== 1'b0 || busy !== 1'b0 || missed_count !== 16'h0) begin
      failures++;
      $display("[TB] FAIL reset_values: dout=%h valid=%b last=%b busy=%b missed=%h required all zero",
               dout, dout_valid, dout_last, busy, missed_count);
    end
  endtask

  task automatic test_ramp();
    do_reset();
    ready_mode = 0;
    channel_id = 5'($urandom);
    while (ramp_val < 100) ramp_push(1'b0);
    ramp_push(1'b1);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL busy_before_edge: got %b required 0", busy);
    end
    ramp_push(1'b0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL busy_after_edge: got %b required 1", busy);
    end
    while (ramp_val < 292) ramp_push(1'b0);
    ramp_push(1'b0);
    checks++;
    if (busy !== 1'b1 || dout_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL readout_start_1: busy=%b valid=%b required busy=1 valid=0", busy, dout_valid);
    end
    ramp_push(1'b0);
    checks++;
    if (dout_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL readout_start_2: valid=%b required 0", dout_valid);
    end
    ramp_push(1'b0);
    checks++;
    if (dout_valid !== 1'b1 || dout !== {4'hA, 7'b0, channel_id}) begin
      failures++;
      $display("[TB] FAIL readout_h0: valid=%b dout=%h required valid=1 dout=%h",
               dout_valid, dout, {4'hA, 7'b0, channel_id});
    end
    drain(1000);
    check_record("ramp", 16'd36, 16'd291);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL busy_after_last: got %b required 0", busy);
    end
    check_missed("ramp");
  endtask

  task automatic test_fill_drop();
    do_reset();
    ready_mode = 2;
    channel_id = 5'($urandom);
    while (ramp_val < 260) ramp_push(ramp_val == 30 || ramp_val == 200);
    drain(2000);
    check_record("fill_drop", 16'd136, 16'd391);
    checks++;
    if (missed_count !== 16'd1) begin
      failures++;
      $display("[TB] FAIL fill_drop_count: got %0d required 1", missed_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ready_mode = 1;
    channel_id = 5'($urandom);
    while (ramp_val < 400)
      ramp_push(ramp_val == 100 || ramp_val == 120 || ramp_val == 140 || ramp_val == 160 ||
                ramp_val == 300 || ramp_val == 320);
    drain(2000);
    checks++;
    if (missed_count !== 16'd5) begin
      failures++;
      $display("[TB] FAIL back_to_back_missed: got %0d required 5", missed_count);
    end
    repeat (100) ramp_push(1'b0);
    ramp_push(1'b1);
    drain(2000);
    checks++;
    if (words_seen != 2 * (REC + 4)) begin
      failures++;
      $display("[TB] FAIL back_to_back_words: got %0d required %0d", words_seen, 2 * (REC + 4));
    end
    check_missed("back_to_back");
  endtask

  task automatic test_wrap();
    do_reset();
    ready_mode = 0;
    channel_id = 5'($urandom);
    while (ramp_val < 500) ramp_push(1'b0);
    ramp_push(1'b1);
    drain(1000);
    check_record("wrap", 16'd436, 16'd691);
    check_missed("wrap");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    ready_mode = 0;
    channel_id = 5'($urandom);
    while (ramp_val < 100) ramp_push(1'b0);
    ramp_push(1'b1);
    while (words_seen < 50 && n < 2000) begin
      ramp_push(1'b0);
      n++;
    end
    checks++;
    if (words_seen < 50) begin
      failures++;
      $display("[TB] FAIL reset_mid_wait: got %0d words required 50", words_seen);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (dout !== 16'h0 || dout_valid !== 1'b0 || dout_last !== 1'b0 || busy !== 1'b0 || missed_count !== 16'h0) begin
      failures++;
      $display("[TB] FAIL reset_mid_values: dout=%h valid=%b last=%b busy=%b missed=%h required all zero",
               dout, dout_valid, dout_last, busy, missed_count);
    end
    enable     = 1'b0;
    trigger_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n    = 1'b1;
    ramp_val   = 0;
    words_seen = 0;
    got_q.delete();
    while (ramp_val < 100) ramp_push(1'b0);
    ramp_push(1'b1);
    drain(1000);
    check_record("reset_mid", 16'd36, 16'd291);
  endtask

  task automatic test_random();
    bit trig = 1'b0;
    do_reset();
    ready_mode = 2;
    channel_id = 5'($urandom);
    timestamp  = {16'($urandom), 32'($urandom)};
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) trig = ~trig;
      push_sample($urandom_range(0, 9) < 8, 16'($urandom), trig);
    end
    drain(3000);
    check_missed("random");
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL random_pending: got %0d words outstanding required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_fill_drop();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t required completion", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] timeout");
  end

endmodule
